// File: rtl/rom_share_arbiter_pkg.sv
// rc4_rom_arb_pkg: shared types for the ROM-sharing arbiter.
//   arb_state_t  : controller states (IDLE / ACTIVE / DRAIN)
//   req_id_w()   : requester-id width for a given number of requesters
//   pipe_entry_t : one read-latency pipeline slot {valid, id}
//   CNT_W        : width of each per-core grant counter
package rc4_rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  // Widest requester id supported (up to 8 cores).
  localparam int ID_W_MAX = 3;
  localparam int CNT_W    = 16;

  function automatic int req_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } pipe_entry_t;

endpackage

// File: rtl/rom_share_arbiter_if.sv
// rom_share_arbiter_if: request/response and ROM-side bundle of the arbiter.
//   halt, req, req_addr        : core side requests (master drives)
//   gnt, rsp_valid, rsp_data   : core side grants and returned bytes
//   rom_addr, rom_rden, rom_q  : single-port ROM connection
//   busy, grant_cnt            : status
// Modports: slave = arbiter, master = cores/ROM/testbench.
interface rom_share_arbiter_if
  import rc4_rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8
);
  logic                      halt;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         rom_addr;
  logic                      rom_rden;
  logic [DATA_W-1:0]         rom_q;
  logic                      busy;
  logic [NUM_REQ*CNT_W-1:0]  grant_cnt;

  modport slave (
    input  halt, req, req_addr, rom_q,
    output gnt, rsp_valid, rsp_data, rom_addr, rom_rden, busy, grant_cnt
  );

  modport master (
    output halt, req, req_addr, rom_q,
    input  gnt, rsp_valid, rsp_data, rom_addr, rom_rden, busy, grant_cnt
  );
endinterface

// File: rtl/rom_share_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   i_req    : request vector
//   i_ptr    : highest-priority index this cycle
//   o_gnt    : one-hot grant (zero when no request)
//   o_winner : encoded index of the granted requester
//   o_any    : 1 when something is granted
module rr_arbiter
  import rc4_rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = req_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_any
);

  logic [ID_W-1:0] w_idx;

  // Walk from the farthest candidate back to the pointer so the closest
  // requester at or above the pointer overwrites any earlier pick.
  always_comb begin
    o_gnt    = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        o_winner     = w_idx;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_share_arbiter.sv
// rom_share_arbiter: shares one single-port ROM (registered address, RD_LAT
// cycles to rom_q) between NUM_REQ cores. Round-robin, one read per cycle,
// responses returned RD_LAT+1 cycles after the grant, in grant order.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : halt/req/req_addr in, gnt/rsp_valid/rsp_data out,
//                  rom_addr/rom_rden out, rom_q in, busy/grant_cnt out
// Build option: ROM_ARB_STATS_EN enables saturating 16-bit per-core grant
// counters; without it grant_cnt is tied to zero.
//
// state  | meaning
// IDLE   | nothing granted, nothing in flight
// ACTIVE | granting reads
// DRAIN  | halted, waiting for in-flight reads to return
module rom_share_arbiter
  import rc4_rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  rom_share_arbiter_if.slave bus
);

  localparam int ID_W = req_id_w(NUM_REQ);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [1:0] ST_DRAIN  = DRAIN;

  logic [NUM_REQ-1:0] w_req_eff;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_winner;
  logic               w_any;
  logic [ADDR_W-1:0]  w_addr_sel;
  logic               w_pipe_busy;
  logic [1:0]         w_state_nxt;

  logic [ID_W-1:0]    r_ptr;
  logic [ADDR_W-1:0]  r_addr_last;
  pipe_entry_t        r_pipe [RD_LAT];
  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

  // Halt blocks new grants in the same cycle.
  assign w_req_eff = bus.halt ? '0 : bus.req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req    (w_req_eff),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_addr_sel = bus.req_addr[int'(w_winner) * ADDR_W +: ADDR_W];

  assign bus.gnt      = w_gnt;
  assign bus.rom_rden = w_any;
  // The ROM registers its address, so the port keeps the last granted
  // address between grants.
  assign bus.rom_addr = w_any ? w_addr_sel : r_addr_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_addr_last <= '0;
    end else if (w_any) begin
      r_ptr       <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      r_addr_last <= w_addr_sel;
    end
  end

  // One slot per ROM latency cycle; the tail lines up with valid rom_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= {w_any, ID_W_MAX'(w_winner)};
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k < RD_LAT; k++) w_pipe_busy = w_pipe_busy | r_pipe[k].valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else if (r_pipe[RD_LAT-1].valid) begin
      r_rsp_valid <= NUM_REQ'(1) << r_pipe[RD_LAT-1].id;
      r_rsp_data  <= bus.rom_q;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (bus.halt && w_pipe_busy)    w_state_nxt = ST_DRAIN;
        else if (!w_any && !w_pipe_busy) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!w_pipe_busy)   w_state_nxt = ST_IDLE;
        else if (!bus.halt) w_state_nxt = ST_ACTIVE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign bus.busy = (r_state != ST_IDLE);

`ifdef ROM_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_gnt[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign bus.grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`else
  assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_rom_share_arbiter.sv
// Self-checking bench for rom_share_arbiter with a behavioural ROM and a
// queue-based reference model of grants and returned bytes.
module tb_rom_share_arbiter;
  import rc4_rom_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rom_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ROM: registered address, data RD_LAT cycles after the address edge.
  logic [DATA_W-1:0] mem    [2**ADDR_W];
  logic [DATA_W-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.rom_rden) q_pipe[0] <= mem[bus.rom_addr];
    for (int k = 1; k < RD_LAT; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign bus.rom_q = q_pipe[RD_LAT-1];

  // Reference model state
  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t               exp_q[$];
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 cyc   = 0;
  int                 m_ptr = 0;
  int                 m_cnt [NUM_REQ];
  int                 exp_winner;
  logic [NUM_REQ-1:0] exp_gnt;
  logic [ADDR_W-1:0]  exp_addr;
  logic [NUM_REQ-1:0] exp_rsp_valid;
  logic [DATA_W-1:0]  exp_rsp_data;

  // Apply one cycle of inputs, advance the model, land on the sampling edge.
  task automatic drive_cycle(input logic [NUM_REQ-1:0] r,
                             input logic [NUM_REQ*ADDR_W-1:0] a,
                             input logic h);
    @(posedge clk);
    #1;
    cyc++;
    bus.req      = r;
    bus.req_addr = a;
    bus.halt     = h;
    exp_gnt      = '0;
    exp_winner   = -1;
    if (!h) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (r[c] && exp_winner < 0) exp_winner = c;
      end
    end
    if (exp_winner >= 0) begin
      exp_gnt[exp_winner] = 1'b1;
      exp_addr = a[exp_winner*ADDR_W +: ADDR_W];
      exp_q.push_back('{due: cyc + RD_LAT + 1, id: exp_winner, data: mem[exp_addr]});
      m_ptr = (exp_winner + 1) % NUM_REQ;
      if (m_cnt[exp_winner] < 65535) m_cnt[exp_winner]++;
    end
    exp_rsp_valid = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rsp_valid[exp_q[0].id] = 1'b1;
      exp_rsp_data = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_addr = '0; bus.halt = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.gnt !== '0) begin n_err++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt); end
    n_cmp++; if (bus.rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    n_cmp++; if (bus.rom_addr !== '0) begin n_err++; $display("FAIL reset_rom_addr got=%h exp=0", bus.rom_addr); end
    n_cmp++; if (bus.rom_rden !== 1'b0) begin n_err++; $display("FAIL reset_rom_rden got=%b exp=0", bus.rom_rden); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.grant_cnt !== '0) begin n_err++; $display("FAIL reset_grant_cnt got=%h exp=0", bus.grant_cnt); end
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  task automatic test_single();
    int n_rsp = 0;
    for (int c = 0; c < RD_LAT + 4; c++) begin
      drive_cycle((c == 0) ? 4'b0001 : 4'b0000, 20'd5, 1'b0);
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL single_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL single_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp_valid); end
      if (exp_gnt != '0) begin
        n_cmp++; if (bus.rom_rden !== 1'b1 || bus.rom_addr !== exp_addr) begin n_err++; $display("FAIL single_rom got=%b/%h exp=1/%h", bus.rom_rden, bus.rom_addr, exp_addr); end
      end
      if (bus.rsp_valid == 4'b0001) begin
        n_rsp++;
        n_cmp++; if (bus.rsp_data !== 8'hA3) begin n_err++; $display("FAIL single_rsp_data got=%h exp=a3", bus.rsp_data); end
      end
    end
    n_cmp++; if (n_rsp != 1) begin n_err++; $display("FAIL single_rsp_count got=%0d exp=1", n_rsp); end
  endtask

  task automatic test_all_req();
    int base;
    logic [NUM_REQ*ADDR_W-1:0] a;
    base = $urandom_range(0, 31);
    for (int c = 0; c < 8 + RD_LAT + 2; c++) begin
      for (int i = 0; i < NUM_REQ; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'((base + c*NUM_REQ + i) % 32);
      drive_cycle((c < 8) ? 4'b1111 : 4'b0000, a, 1'b0);
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL all_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL all_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_cmp++; if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL all_rsp_data cyc=%0d got=%h exp=%h", cyc, bus.rsp_data, exp_rsp_data); end
      end
    end
  endtask

  task automatic test_stream();
    logic [NUM_REQ*ADDR_W-1:0] a;
    int n_rsp = 0;
    for (int c = 0; c < 32 + RD_LAT + 2; c++) begin
      a = '0;
      a[2*ADDR_W +: ADDR_W] = ADDR_W'(c % 32);
      drive_cycle((c < 32) ? 4'b0100 : 4'b0000, a, 1'b0);
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL stream_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL stream_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_cmp++; if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL stream_rsp_data cyc=%0d got=%h exp=%h", cyc, bus.rsp_data, exp_rsp_data); end
      end
      if (bus.rsp_valid == 4'b0100) n_rsp++;
    end
    n_cmp++; if (n_rsp != 32) begin n_err++; $display("FAIL stream_rsp_count got=%0d exp=32", n_rsp); end
  endtask

  task automatic test_halt();
    logic [NUM_REQ*ADDR_W-1:0] a;
    for (int c = 0; c < 12; c++) begin
      a = 20'($urandom);
      // 4 grants, then 6 halted cycles with the request still up, then idle
      drive_cycle((c < 10) ? 4'b0001 : 4'b0000, a, (c >= 4 && c < 10));
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL halt_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL halt_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_cmp++; if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL halt_rsp_data cyc=%0d got=%h exp=%h", cyc, bus.rsp_data, exp_rsp_data); end
      end
      if (c == 5) begin
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL halt_busy_drain got=%b exp=1", bus.busy); end
      end
      if (c == 9) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL halt_busy_idle got=%b exp=0", bus.busy); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(4'b0010, 20'($urandom), 1'b0);
    n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rstmid_gnt got=%b exp=%b", bus.gnt, exp_gnt); end
    @(posedge clk); #1;
    reset_n = 1'b0; bus.req = '0; bus.halt = 1'b0;
    model_reset();
    @(negedge clk);
    n_cmp++; if ({bus.gnt, bus.rsp_valid, bus.rom_rden, bus.busy} !== '0) begin n_err++; $display("FAIL rstmid_ctrl got=%b exp=0", {bus.gnt, bus.rsp_valid, bus.rom_rden, bus.busy}); end
    n_cmp++; if ({bus.rsp_data, bus.rom_addr} !== '0) begin n_err++; $display("FAIL rstmid_data got=%h exp=0", {bus.rsp_data, bus.rom_addr}); end
    @(posedge clk); #1; reset_n = 1'b1;
    for (int c = 0; c < RD_LAT + 3; c++) begin
      drive_cycle(4'b0000, '0, 1'b0);
      n_cmp++; if (bus.rsp_valid !== '0) begin n_err++; $display("FAIL rstmid_no_rsp cyc=%0d got=%b exp=0", cyc, bus.rsp_valid); end
    end
    // Pointer back at 0: full request set is granted 0,1,2,3
    for (int c = 0; c < NUM_REQ; c++) begin
      drive_cycle(4'b1111, 20'($urandom), 1'b0);
      n_cmp++; if (bus.gnt !== (4'b0001 << c)) begin n_err++; $display("FAIL rstmid_order cyc=%0d got=%b exp=%b", cyc, bus.gnt, 4'b0001 << c); end
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] r;
    for (int c = 0; c < 400; c++) begin
      r = (c < 395) ? NUM_REQ'($urandom) : '0;
      drive_cycle(r, 20'($urandom), ($urandom_range(0, 7) == 0));
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_cmp++; if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL rand_rsp_data cyc=%0d got=%h exp=%h", cyc, bus.rsp_data, exp_rsp_data); end
      end
      if (exp_gnt != '0) begin
        n_cmp++; if (bus.rom_addr !== exp_addr) begin n_err++; $display("FAIL rand_rom_addr cyc=%0d got=%h exp=%h", cyc, bus.rom_addr, exp_addr); end
      end
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_c;
`ifdef ROM_ARB_STATS_EN
    repeat (70000) drive_cycle(4'b0010, 20'($urandom), 1'b0);
    n_cmp++; if (bus.grant_cnt[16 +: 16] !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat got=%h exp=ffff", bus.grant_cnt[16 +: 16]); end
`else
    repeat (50) drive_cycle(4'b0010, 20'($urandom), 1'b0);
`endif
    repeat (RD_LAT + 2) drive_cycle(4'b0000, '0, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ROM_ARB_STATS_EN
      exp_c = 16'(m_cnt[i]);
`else
      exp_c = 16'h0000;
`endif
      n_cmp++; if (bus.grant_cnt[i*16 +: 16] !== exp_c) begin n_err++; $display("FAIL stats_cnt%0d got=%h exp=%h", i, bus.grant_cnt[i*16 +: 16], exp_c); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
    mem[5] = 8'hA3;
    for (int k = 0; k < RD_LAT; k++) q_pipe[k] = '0;
    test_reset();
    test_single();
    test_all_req();
    test_stream();
    test_halt();
    test_reset_mid();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

endmodule
